// File: rtl/exe_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// exe_muldiv_ctrl_if : EX-stage / divider / multiplier signals seen by the mul-div sequencer
// Rev 1.0
// ============================================================================
interface exe_muldiv_ctrl_if;
  logic        valid_i;
  logic        is_div_i;
  logic        is_mul_i;
  logic        flush_i;
  logic        except_i;
  logic        hold_i;
  logic        div_ready_i;
  logic [31:0] div_hi_i;
  logic [31:0] div_lo_i;
  logic [31:0] mul_hi_i;
  logic [31:0] mul_lo_i;
  logic        div_start_o;
  logic        div_cancel_o;
  logic        stall_o;
  logic        res_valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_err_o;

  modport master (
    output valid_i, is_div_i, is_mul_i, flush_i, except_i, hold_i,
    output div_ready_i, div_hi_i, div_lo_i, mul_hi_i, mul_lo_i,
    input  div_start_o, div_cancel_o, stall_o, res_valid_o, hi_o, lo_o, div_err_o
  );

  modport slave (
    input  valid_i, is_div_i, is_mul_i, flush_i, except_i, hold_i,
    input  div_ready_i, div_hi_i, div_lo_i, mul_hi_i, mul_lo_i,
    output div_start_o, div_cancel_o, stall_o, res_valid_o, hi_o, lo_o, div_err_o
  );
endinterface
`default_nettype wire

// File: rtl/exe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// exe_muldiv_ctrl : sequences divider / pipelined multiplier for the EX instruction
// Rev 1.0
// ============================================================================
module exe_muldiv_ctrl #(
  parameter int MUL_CYCLES  = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input wire               clk,
  input wire               rst,
  exe_muldiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_cnt_max = '1;
  localparam logic [CW-1:0] c_cnt_tmo = CW'(DIV_TIMEOUT);
  localparam logic [CW-1:0] c_mul_last = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_BUSY = 2'd1,
    S_MUL_BUSY = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          err_q;

  logic kill;
  logic issue;
  logic issue_div;
  logic issue_mul;
  logic div_kill;
  logic div_hit;
  logic div_tmo;
  logic mul_hit;

  always_comb begin
    kill      = bus.flush_i | bus.except_i;
    issue     = (state_q == S_IDLE) & bus.valid_i & ~kill & (bus.is_div_i | bus.is_mul_i);
    issue_div = issue & bus.is_div_i;
    issue_mul = issue & ~bus.is_div_i;
    div_kill  = (state_q == S_DIV_BUSY) & kill;
    div_hit   = (state_q == S_DIV_BUSY) & ~kill & bus.div_ready_i;
    div_tmo   = (state_q == S_DIV_BUSY) & ~kill & ~bus.div_ready_i & (cnt_q == c_cnt_tmo);
    mul_hit   = (state_q == S_MUL_BUSY) & ~kill & (cnt_q == c_mul_last);
  end

  // Handshake outputs are decoded from state and inputs; reset masks them immediately.
  always_comb begin
    bus.div_start_o  = rst & issue_div;
    bus.div_cancel_o = rst & (div_kill | div_tmo);
    bus.stall_o      = rst & (issue | (state_q == S_DIV_BUSY) | (state_q == S_MUL_BUSY));
    bus.res_valid_o  = rst & (state_q == S_DONE);
    bus.hi_o         = hi_q;
    bus.lo_o         = lo_q;
    bus.div_err_o    = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_div) begin
            state_q <= S_DIV_BUSY;
            cnt_q   <= c_cnt_one;
          end else if (issue_mul) begin
            if (MUL_CYCLES == 1) begin
              hi_q    <= bus.mul_hi_i;
              lo_q    <= bus.mul_lo_i;
              state_q <= S_DONE;
            end else begin
              state_q <= S_MUL_BUSY;
              cnt_q   <= c_cnt_one;
            end
          end
        end

        S_DIV_BUSY: begin
          if (cnt_q != c_cnt_max) begin
            cnt_q <= cnt_q + c_cnt_one;
          end
          if (div_kill) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (div_hit) begin
            hi_q    <= bus.div_hi_i;
            lo_q    <= bus.div_lo_i;
            state_q <= S_DONE;
            cnt_q   <= '0;
          end else if (div_tmo) begin
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
            cnt_q   <= '0;
          end
        end

        S_MUL_BUSY: begin
          if (cnt_q != c_cnt_max) begin
            cnt_q <= cnt_q + c_cnt_one;
          end
          // The multiplier is pipelined, so a kill just drops the result.
          if (kill) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (mul_hit) begin
            hi_q    <= bus.mul_hi_i;
            lo_q    <= bus.mul_lo_i;
            state_q <= S_DONE;
            cnt_q   <= '0;
          end
        end

        S_DONE: begin
          if (kill | ~bus.hold_i) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// tb_exe_muldiv_ctrl : scoreboard bench for exe_muldiv_ctrl (MUL_CYCLES=2, DIV_TIMEOUT=64)
// Rev 1.0
// ============================================================================
module tb_exe_muldiv_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  exe_muldiv_ctrl_if bus();

  exe_muldiv_ctrl #(.MUL_CYCLES(2), .DIV_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_cancel = 0;
  int   stall_run = 0;
  logic prev_rv = 1'b0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: samples 1 ns after the stimulus edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bus.div_start_o) n_start++;
    if (bus.div_cancel_o) n_cancel++;
    if (bus.div_start_o || bus.div_cancel_o)
      check_eq("start_and_cancel", {63'd0, bus.div_start_o & bus.div_cancel_o}, 64'd0);
    if (bus.stall_o) stall_run++;
    if (bus.res_valid_o && !prev_rv) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("res_hi", {32'd0, bus.hi_o}, {32'd0, e.hi});
        check_eq("res_lo", {32'd0, bus.lo_o}, {32'd0, e.lo});
        check_eq("res_stalls", 64'(stall_run), 64'(e.stalls));
        check_eq("res_err", {63'd0, bus.div_err_o}, {63'd0, e.err});
      end
    end
    prev_rv = bus.res_valid_o;
    if (!bus.stall_o) stall_run = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int c0;
    int k;
    rst = 1'b0;
    bus.valid_i = 0; bus.is_div_i = 0; bus.is_mul_i = 0;
    bus.flush_i = 0; bus.except_i = 0; bus.hold_i = 0;
    bus.div_ready_i = 0; bus.div_hi_i = 0; bus.div_lo_i = 0;
    bus.mul_hi_i = 0; bus.mul_lo_i = 0;

    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_ctrl", {59'd0, bus.stall_o, bus.div_start_o, bus.div_cancel_o, bus.res_valid_o, bus.div_err_o}, 64'd0);
    check_eq("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Divide, ready pulse 10 cycles after start.
    @(negedge clk);
    bus.valid_i = 1; bus.is_div_i = 1;
    sb.push_back('{32'h3, 32'h7, 11, 1'b0});
    s0 = n_start;
    #2 check_eq("div_start", {63'd0, bus.div_start_o}, 64'd1);
    repeat (9) @(negedge clk);
    @(negedge clk); bus.div_ready_i = 1; bus.div_hi_i = 32'h3; bus.div_lo_i = 32'h7;
    @(negedge clk); bus.div_ready_i = 0; bus.div_hi_i = 32'hDEAD; bus.div_lo_i = 32'hBEEF;
    #2 check_eq("div_done", {63'd0, bus.res_valid_o}, 64'd1);
    @(negedge clk); bus.valid_i = 0; bus.is_div_i = 0;
    #2 check_eq("div_idle_stall", {63'd0, bus.stall_o}, 64'd0);
    check_eq("div_one_start", 64'(n_start - s0), 64'd1);

    // Multiply: exactly two stall cycles.
    @(negedge clk);
    bus.valid_i = 1; bus.is_mul_i = 1; bus.mul_hi_i = 32'h1; bus.mul_lo_i = 32'hFFFF_FFFE;
    sb.push_back('{32'h1, 32'hFFFF_FFFE, 2, 1'b0});
    #2 check_eq("mul_issue", {62'd0, bus.stall_o, bus.div_start_o}, 64'd2);
    @(negedge clk);
    @(negedge clk);
    #2 check_eq("mul_done", {63'd0, bus.res_valid_o}, 64'd1);
    @(negedge clk); bus.valid_i = 0; bus.is_mul_i = 0; bus.mul_hi_i = 0; bus.mul_lo_i = 0;
    #2 check_eq("mul_lo_kept", {32'd0, bus.lo_o}, 64'hFFFF_FFFE);

    // Divide then held in DONE for five cycles.
    @(negedge clk);
    bus.valid_i = 1; bus.is_div_i = 1; bus.hold_i = 1;
    sb.push_back('{32'hA, 32'hB, 5, 1'b0});
    s0 = n_start;
    repeat (3) @(negedge clk);
    @(negedge clk); bus.div_ready_i = 1; bus.div_hi_i = 32'hA; bus.div_lo_i = 32'hB;
    @(negedge clk); bus.div_ready_i = 0; bus.div_hi_i = 0; bus.div_lo_i = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check_eq("hold_state", {62'd0, bus.res_valid_o, bus.stall_o}, 64'd2);
      check_eq("hold_hilo", {bus.hi_o, bus.lo_o}, {32'hA, 32'hB});
      @(negedge clk);
    end
    bus.hold_i = 0;
    @(negedge clk); bus.valid_i = 0; bus.is_div_i = 0;
    #2 check_eq("hold_one_start", 64'(n_start - s0), 64'd1);

    // Flush three cycles into DIV_BUSY, colliding with div_ready.
    @(negedge clk);
    bus.valid_i = 1; bus.is_div_i = 1;
    c0 = n_cancel;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.flush_i = 1; bus.div_ready_i = 1; bus.div_hi_i = 32'h55; bus.div_lo_i = 32'h66;
    #2 check_eq("flush_cancel", {63'd0, bus.div_cancel_o}, 64'd1);
    @(negedge clk); bus.flush_i = 0; bus.div_ready_i = 0; bus.valid_i = 0; bus.is_div_i = 0;
    #2 check_eq("flush_idle", {62'd0, bus.stall_o, bus.res_valid_o}, 64'd0);
    check_eq("flush_hilo", {bus.hi_o, bus.lo_o}, {32'hA, 32'hB});
    check_eq("flush_one_cancel", 64'(n_cancel - c0), 64'd1);

    // Divider never answers: timeout.
    @(negedge clk);
    bus.valid_i = 1; bus.is_div_i = 1;
    sb.push_back('{32'h0, 32'h0, 65, 1'b1});
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      #2;
      if (bus.div_cancel_o) begin
        k = i;
        break;
      end
    end
    check_eq("tmo_cycles", 64'(k), 64'd64);
    @(negedge clk);
    #2 check_eq("tmo_done", {61'd0, bus.res_valid_o, bus.stall_o, bus.div_err_o}, 64'd5);
    @(negedge clk); bus.valid_i = 0; bus.is_div_i = 0;

    // Multiply after timeout: error flag stays set.
    @(negedge clk);
    bus.valid_i = 1; bus.is_mul_i = 1; bus.mul_hi_i = 32'h1234_5678; bus.mul_lo_i = 32'h9ABC_DEF0;
    sb.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b1});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.valid_i = 0; bus.is_mul_i = 0;

    // Reset in the middle of DIV_BUSY.
    @(negedge clk);
    bus.valid_i = 1; bus.is_div_i = 1;
    c0 = n_cancel;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2 check_eq("rstmid_comb", {61'd0, bus.stall_o, bus.div_cancel_o, bus.div_start_o}, 64'd0);
    @(negedge clk);
    #2 check_eq("rstmid_ctrl", {60'd0, bus.stall_o, bus.res_valid_o, bus.div_cancel_o, bus.div_err_o}, 64'd0);
    check_eq("rstmid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check_eq("rstmid_no_cancel", 64'(n_cancel - c0), 64'd0);
    @(negedge clk); rst = 1'b1;
    sb.push_back('{32'hC, 32'hD, 3, 1'b0});
    #2 check_eq("rstmid_reissue", {63'd0, bus.div_start_o}, 64'd1);
    @(negedge clk);
    @(negedge clk); bus.div_ready_i = 1; bus.div_hi_i = 32'hC; bus.div_lo_i = 32'hD;
    @(negedge clk); bus.div_ready_i = 0;
    @(negedge clk); bus.valid_i = 0; bus.is_div_i = 0;
    repeat (3) @(negedge clk);
    #2 check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
